// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM for a multicycle MIPS-subset datapath
// sharing one memory port for instruction fetch and data access.
// Adds a memory timeout, a sticky illegal-instruction fault, a retired
// instruction counter and link writeback for jal.
// Optional feature: define MCU_JR_EN to decode jr (R-type funct 001000).
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             write_to_register,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       cnt_alu,
  output logic [1:0]       register_dst,
  output logic [1:0]       memory_to_register,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t          state;
  state_t          next_state;
  logic            retire;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_wait_state;
  logic            timed_out;
  logic [2:0]      rtype_alu;
  logic            rtype_ok;
  logic            jr_hit;

`ifdef MCU_JR_EN
  localparam logic [5:0] FN_JR = 6'b001000;
  assign jr_hit = (op_code == OP_RTYPE) && (funct == FN_JR);
`else
  assign jr_hit = 1'b0;
`endif

  // A wait state times out only when the limit was already reached and memory still is not ready
  assign mem_wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timed_out      = (MEM_TIMEOUT != 0) && !mem_ready &&
                          (wait_cnt >= TO_W'(MEM_TIMEOUT));

  // R-type funct to ALU control; unknown functs are flagged as illegal
  always_comb begin
    rtype_alu = 3'b000;
    rtype_ok  = 1'b1;
    case (funct)
      6'b100000: rtype_alu = 3'b010;
      6'b100010: rtype_alu = 3'b110;
      6'b100100: rtype_alu = 3'b000;
      6'b100101: rtype_alu = 3'b001;
      6'b101010: rtype_alu = 3'b111;
      default:   rtype_ok  = 1'b0;
    endcase
  end

  // Next-state selection; final states flag retirement as they return to FETCH
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      next_state = S_DECODE;
        else if (timed_out) next_state = S_FAULT;
      end
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW:     next_state = S_MEMADR;
          OP_RTYPE:         next_state = jr_hit ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_ADDI, OP_ANDI: next_state = S_IEXEC;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          default:          next_state = S_FAULT;
        endcase
      end
      S_MEMADR: next_state = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      next_state = S_MEMWB;
        else if (timed_out) next_state = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (timed_out) begin
          next_state = S_FAULT;
        end
      end
      S_EXEC:   next_state = rtype_ok ? S_RWB : S_FAULT;
      S_IEXEC:  next_state = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP, S_JAL, S_JR: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  // State, memory wait counter and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + CNT_W'(1);
      if (next_state != state)
        wait_cnt <= '0;
      else if (mem_wait_state && !mem_ready)
        wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Datapath controls decoded from the current state, zero unless listed
  always_comb begin
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    iord               = 1'b0;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    write_to_register  = 1'b0;
    pc_src             = 2'b00;
    alu_src_a          = 1'b0;
    alu_src_b          = 2'b00;
    cnt_alu            = 3'b000;
    register_dst       = 2'b00;
    memory_to_register = 2'b00;
    fault              = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        cnt_alu   = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        cnt_alu   = 3'b010;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        cnt_alu   = 3'b010;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        write_to_register  = 1'b1;
        memory_to_register = 2'b01;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        cnt_alu   = rtype_alu;
      end
      S_RWB: begin
        write_to_register = 1'b1;
        register_dst      = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        cnt_alu   = 3'b110;
        pc_src    = 2'b01;
        pc_write  = ((op_code == OP_BEQ) && zero) || ((op_code == OP_BNE) && !zero);
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        cnt_alu   = (op_code == OP_ANDI) ? 3'b000 : 3'b010;
      end
      S_IWB: write_to_register = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_JAL: begin
        pc_write           = 1'b1;
        pc_src             = 2'b10;
        write_to_register  = 1'b1;
        register_dst       = 2'b10;
        memory_to_register = 2'b10;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream with random memory
// wait cycles, checked every cycle against a per-instruction state-plan model,
// plus directed cases pinned with literal expectations.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int TO_W        = 8;
`ifdef MCU_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op_code = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_write, write_to_register;
  logic [1:0]       pc_src, alu_src_b, register_dst, memory_to_register;
  logic             alu_src_a, fault;
  logic [2:0]       cnt_alu;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;
  logic [18:0]      dut_vec;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W(CNT_W),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_code(op_code),
    .funct(funct),
    .zero(zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .iord(iord),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .write_to_register(write_to_register),
    .pc_src(pc_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .cnt_alu(cnt_alu),
    .register_dst(register_dst),
    .memory_to_register(memory_to_register),
    .fault(fault),
    .instret(instret),
    .state_o(state_o)
  );

  assign dut_vec = {mem_req, mem_we, iord, ir_write, pc_write, write_to_register,
                    pc_src, alu_src_a, alu_src_b, cnt_alu, register_dst,
                    memory_to_register, fault};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         zf;
    bit         z;
  } instr_t;

  instr_t forced_q[$];
  int     checks = 0;
  int     errors = 0;

  // Model: each instruction is a list of spec state numbers starting at FETCH
  int plan[$];
  int m_state = 0;
  int m_idx = 0;
  int m_wcnt = 0;
  int m_instret = 0;
  bit m_new_instr = 1'b0;
  int ready_mode = 0;
  bit zero_forced = 1'b0;
  bit zero_val = 1'b0;

  function automatic bit valid_fn(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn);
    plan.delete();
    plan.push_back(1);
    plan.push_back(2);
    case (op)
      6'b100011: begin plan.push_back(3); plan.push_back(4); plan.push_back(5); end
      6'b101011: begin plan.push_back(3); plan.push_back(6); end
      6'b000000: begin
        if (JR_EN && fn == 6'b001000) plan.push_back(14);
        else begin
          plan.push_back(7);
          plan.push_back(valid_fn(fn) ? 8 : 15);
        end
      end
      6'b000100, 6'b000101: plan.push_back(9);
      6'b001000, 6'b001100: begin plan.push_back(10); plan.push_back(11); end
      6'b000010: plan.push_back(12);
      6'b000011: plan.push_back(13);
      default:   plan.push_back(15);
    endcase
    m_idx = 0;
  endtask

  // Expected output vector for a spec state and the current inputs
  function automatic logic [18:0] expect_vec(input int s, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z,
                                             input logic rdy);
    logic mreq = 0, mwe = 0, io = 0, irw = 0, pcw = 0, wr = 0, asa = 0, flt = 0;
    logic [1:0] pcs = 0, asb = 0, dst = 0, m2r = 0;
    logic [2:0] alu = 0;
    case (s)
      1:  begin mreq = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
      2:  begin asb = 2'b11; alu = 3'b010; end
      3:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      4:  begin mreq = 1; io = 1; end
      5:  begin wr = 1; m2r = 2'b01; end
      6:  begin mreq = 1; mwe = 1; io = 1; end
      7:  begin
        asa = 1;
        if (fn == 6'b100000) alu = 3'b010;
        else if (fn == 6'b100010) alu = 3'b110;
        else if (fn == 6'b100101) alu = 3'b001;
        else if (fn == 6'b101010) alu = 3'b111;
      end
      8:  begin wr = 1; dst = 2'b01; end
      9:  begin
        asa = 1; alu = 3'b110; pcs = 2'b01;
        pcw = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
      end
      10: begin asa = 1; asb = 2'b10; alu = (op == 6'b001100) ? 3'b000 : 3'b010; end
      11: wr = 1;
      12: begin pcw = 1; pcs = 2'b10; end
      13: begin pcw = 1; pcs = 2'b10; wr = 1; dst = 2'b10; m2r = 2'b10; end
      14: begin pcw = 1; pcs = 2'b11; end
      15: flt = 1;
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, wr, pcs, asa, asb, alu, dst, m2r, flt};
  endfunction

  task automatic check_output();
    logic [18:0] ev;
    ev = expect_vec(m_state, op_code, funct, zero, mem_ready);
    checks++;
    if (dut_vec !== ev || state_o !== 4'(m_state) || instret !== CNT_W'(m_instret)) begin
      errors++;
      $display("[TB] FAIL cycle_check t=%0t: got state=%0d instret=%0d outs=%b, want state=%0d instret=%0d outs=%b",
               $time, state_o, instret, dut_vec, m_state, m_instret, ev);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Advance the model by one clock using the inputs held during this cycle
  task automatic model_advance();
    if (m_state == 15) return;
    if (m_state == 0) begin
      m_state = 1; m_new_instr = 1; m_wcnt = 0;
      return;
    end
    if ((m_state == 1 || m_state == 4 || m_state == 6) && !mem_ready) begin
      if (MEM_TIMEOUT != 0 && m_wcnt >= MEM_TIMEOUT) m_state = 15;
      else m_wcnt++;
      return;
    end
    m_wcnt = 0;
    m_idx++;
    if (m_idx >= plan.size()) begin
      m_instret = (m_instret + 1) % (1 << CNT_W);
      m_state = 1;
      m_new_instr = 1;
    end else begin
      m_state = plan[m_idx];
    end
  endtask

  task automatic pick_random(output logic [5:0] op, output logic [5:0] fn);
    int r;
    int k;
    r = $urandom_range(0, 99);
    fn = 6'($urandom);
    if (r < 12) op = 6'b100011;
    else if (r < 24) op = 6'b101011;
    else if (r < 44) begin
      op = 6'b000000;
      k = $urandom_range(0, 9);
      case (k)
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4, 5, 6: fn = 6'b101010;
        7: fn = 6'b001000;
        default: ;
      endcase
    end
    else if (r < 54) op = 6'b000100;
    else if (r < 64) op = 6'b000101;
    else if (r < 72) op = 6'b001000;
    else if (r < 80) op = 6'b001100;
    else if (r < 88) op = 6'b000010;
    else if (r < 96) op = 6'b000011;
    else op = 6'($urandom);
  endtask

  task automatic apply_stimulus();
    instr_t     f;
    logic [5:0] op;
    logic [5:0] fn;
    if (m_new_instr) begin
      m_new_instr = 0;
      if (forced_q.size() > 0) begin
        f = forced_q.pop_front();
        op = f.op; fn = f.fn; zero_forced = f.zf; zero_val = f.z;
      end else begin
        pick_random(op, fn);
        zero_forced = 0;
      end
      op_code = op;
      funct = fn;
      build_plan(op, fn);
    end
    case (ready_mode)
      1:       mem_ready = 1'b1;
      2:       mem_ready = 1'b0;
      default: mem_ready = ($urandom_range(0, 3) != 0);
    endcase
    zero = zero_forced ? zero_val : 1'($urandom);
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    apply_stimulus();
    #1;
    check_output();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_state = 0; m_wcnt = 0; m_instret = 0; m_new_instr = 0; zero_forced = 0;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input bit zf, input bit z);
    instr_t i;
    i.op = op; i.fn = fn; i.zf = zf; i.z = z;
    return i;
  endfunction

  initial begin
    int want_seq[6];
    int faulted;

    // Reset state
    do_reset();
    check_lit("reset_state", int'(state_o), 0);
    check_lit("reset_instret", int'(instret), 0);
    check_lit("reset_fault", int'(fault), 0);

    // lw with zero-wait memory, then beq z=1, beq z=0, bne z=0
    ready_mode = 1;
    forced_q.push_back(mk(6'b100011, 6'd0, 0, 0));
    forced_q.push_back(mk(6'b000100, 6'd0, 1, 1));
    forced_q.push_back(mk(6'b000100, 6'd0, 1, 0));
    forced_q.push_back(mk(6'b000101, 6'd0, 1, 0));
    want_seq = '{1, 2, 3, 4, 5, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      check_lit($sformatf("lw_state_%0d", i), int'(state_o), want_seq[i]);
      if (i == 4) begin
        check_lit("lw_memwb_wr", int'(write_to_register), 1);
        check_lit("lw_memwb_m2r", int'(memory_to_register), 1);
        check_lit("lw_memwb_dst", int'(register_dst), 0);
      end
    end
    check_lit("lw_instret", int'(instret), 1);
    for (int b = 0; b < 3; b++) begin
      step();
      step();
      check_lit($sformatf("branch%0d_state", b), int'(state_o), 9);
      check_lit($sformatf("branch%0d_pc_write", b), int'(pc_write), (b == 1) ? 0 : 1);
      check_lit($sformatf("branch%0d_pc_src", b), int'(pc_src), 1);
      step();
    end
    check_lit("branch_instret", int'(instret), 4);

    // Fetch timeout
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 5; i++) step();
    check_lit("timeout_still_fetch", int'(state_o), 1);
    step();
    check_lit("timeout_state", int'(state_o), 15);
    check_lit("timeout_fault", int'(fault), 1);
    step();
    step();
    check_lit("fault_sticky", int'(state_o), 15);
    do_reset();
    check_lit("fault_cleared", int'(fault), 0);
    check_lit("fault_reset_state", int'(state_o), 0);

    // jal then the jr encoding
    ready_mode = 1;
    forced_q.push_back(mk(6'b000011, 6'd0, 0, 0));
    forced_q.push_back(mk(6'b000000, 6'b001000, 0, 0));
    step();
    step();
    step();
    check_lit("jal_state", int'(state_o), 13);
    check_lit("jal_pc_write", int'(pc_write), 1);
    check_lit("jal_pc_src", int'(pc_src), 2);
    check_lit("jal_wr", int'(write_to_register), 1);
    check_lit("jal_dst", int'(register_dst), 2);
    check_lit("jal_m2r", int'(memory_to_register), 2);
    step();
    check_lit("jal_latency_fetch", int'(state_o), 1);
    step();
    step();
    if (JR_EN) begin
      check_lit("jr_pc_src", int'(pc_src), 3);
      step();
      check_lit("jr_instret", int'(instret), 2);
    end else begin
      check_lit("jr_disabled_exec", int'(state_o), 7);
      step();
      check_lit("jr_disabled_fault", int'(state_o), 15);
    end

    // Illegal opcode
    do_reset();
    forced_q.push_back(mk(6'b111111, 6'd0, 0, 0));
    step();
    step();
    step();
    check_lit("illegal_op_fault", int'(state_o), 15);

    // instret wrap with 4-bit counter
    do_reset();
    for (int i = 0; i < 16; i++) forced_q.push_back(mk(6'b000010, 6'd0, 0, 0));
    step();
    for (int i = 0; i < 45; i++) step();
    check_lit("wrap_instret_15", int'(instret), 15);
    for (int i = 0; i < 3; i++) step();
    check_lit("wrap_instret_0", int'(instret), 0);

    // Reset asserted while a store is in MEMWR
    do_reset();
    forced_q.delete();
    forced_q.push_back(mk(6'b101011, 6'd0, 0, 0));
    for (int i = 0; i < 4; i++) step();
    check_lit("sw_memwr_we", int'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check_lit("abort_mem_we", int'(mem_we), 0);
    check_lit("abort_state", int'(state_o), 0);
    do_reset();

    // Random instruction stream with random memory waits
    ready_mode = 0;
    faulted = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (m_state == 15) faulted++;
      if (faulted >= 3 || $urandom_range(0, 499) == 0) begin
        faulted = 0;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
